// File: rtl/ser_word_rx.sv
// ============================================================================
// Module   : ser_word_rx
// Brief    : Serial-to-parallel word receiver, MSB first. Assembles WIDTH-bit
//            words from SEN-qualified serial bits started by SYNC, presents
//            them in a holding register with a DV/RD handshake, and reports
//            framing (ERR), overrun (OVR) and parity (PERR) faults on sticky
//            flags.
// Options  : define SER_WORD_RX_PARITY_EN to expect one even-parity bit after
//            each word (adds the PAR state and activates PERR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_word_rx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             SIN,
    input  logic             SEN,
    input  logic             SYNC,
    input  logic             RD,
    output logic [WIDTH-1:0] D,
    output logic             DV,
    output logic             BUSY,
    output logic             ERR,
    output logic             OVR,
    output logic             PERR
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef SER_WORD_RX_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_SHIFT = 2'd1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               err_q;
    logic [WIDTH-1:0]   d_q;
    logic               dv_q;
    logic               ovr_q;

    // Shift register contents after taking the current serial bit
    logic [WIDTH-1:0]   shr_d;
    // The bit now being sampled is the last data bit of the word
    logic               last_bit;
    // A word finishes on this edge, with its assembled value
    logic               done_d;
    logic [WIDTH-1:0]   word_d;
`ifdef SER_WORD_RX_PARITY_EN
    logic               perr_q;
    logic               par_bad;
`endif

    assign shr_d    = {shr_q[WIDTH-2:0], SIN};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Detect word completion and pick the word value that completes
    always_comb begin
        done_d = 1'b0;
        word_d = shr_d;
`ifdef SER_WORD_RX_PARITY_EN
        par_bad = 1'b0;
`endif
        case (state_q)
`ifdef SER_WORD_RX_PARITY_EN
            S_PAR: begin
                // Data is already complete in shr; SIN is the parity bit
                if (SEN && !SYNC) begin
                    done_d  = 1'b1;
                    word_d  = shr_q;
                    par_bad = (SIN != (^shr_q));
                end
            end
`else
            S_SHIFT: begin
                if (SEN && !SYNC && last_bit) begin
                    done_d = 1'b1;
                end
            end
`endif
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Word assembly state machine: sync detection, shifting, framing errors
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            state_q <= S_IDLE;
            shr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (SEN) begin
            if (SYNC) begin
                // A SYNC while a word is in progress abandons it
                if (state_q != S_IDLE) begin
                    err_q <= 1'b1;
                end
                shr_q   <= shr_d;
                cnt_q   <= CNT_W'(1);
                state_q <= S_SHIFT;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_SHIFT: begin
                        shr_q <= shr_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_bit) begin
`ifdef SER_WORD_RX_PARITY_EN
                            state_q <= S_PAR;
`else
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
`endif
                        end
                    end
`ifdef SER_WORD_RX_PARITY_EN
                    S_PAR: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
`endif
                    default: begin
                        // Bits without a preceding SYNC are not part of a word
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Holding register handshake and overrun tracking
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            d_q   <= '0;
            dv_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else if (done_d) begin
            // A same-cycle RD frees the holding register for the new word
            if (!dv_q || RD) begin
                d_q  <= word_d;
                dv_q <= 1'b1;
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (RD && dv_q) begin
            dv_q <= 1'b0;
        end
    end

`ifdef SER_WORD_RX_PARITY_EN
    // Sticky parity error, raised when a received parity bit disagrees
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            perr_q <= 1'b0;
        end else if (done_d && par_bad) begin
            perr_q <= 1'b1;
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    assign D    = d_q;
    assign DV   = dv_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;
    assign OVR  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ser_word_rx.sv
// ============================================================================
// Module   : tb_ser_word_rx
// Brief    : Self-checking bench for ser_word_rx. Directed scenarios followed
//            by random serial traffic, all compared against a queue-based
//            reference model of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_word_rx;

    localparam int WIDTH = 8;
`ifdef SER_WORD_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS = PAR_EN ? WIDTH + 1 : WIDTH;

    logic             CLK = 1'b0;
    logic             Clr;
    logic             SIN;
    logic             SEN;
    logic             SYNC;
    logic             RD;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic             BUSY;
    logic             ERR;
    logic             OVR;
    logic             PERR;

    ser_word_rx #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .Clr  (Clr),
        .SIN  (SIN),
        .SEN  (SEN),
        .SYNC (SYNC),
        .RD   (RD),
        .D    (D),
        .DV   (DV),
        .BUSY (BUSY),
        .ERR  (ERR),
        .OVR  (OVR),
        .PERR (PERR)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits collected since the last SYNC, plus output state
    bit               m_active;
    bit               m_q[$];
    logic [WIDTH-1:0] m_d;
    bit               m_dv, m_err, m_ovr, m_perr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_q.delete();
        m_d    = '0;
        m_dv   = 1'b0;
        m_err  = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge(input bit sen, input bit sync, input bit sin, input bit rd);
        bit               done;
        logic [WIDTH-1:0] word;
        done = 1'b0;
        word = '0;
        if (sen) begin
            if (sync) begin
                if (m_active) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(sin);
                m_active = 1'b1;
            end else if (m_active) begin
                m_q.push_back(sin);
                if (m_q.size() == NBITS) begin
                    for (int i = 0; i < WIDTH; i++) word = (word << 1) | WIDTH'(m_q[i]);
                    if (PAR_EN && (m_q[WIDTH] != bit'($countones(word) % 2))) m_perr = 1'b1;
                    done     = 1'b1;
                    m_active = 1'b0;
                    m_q.delete();
                end
            end
        end
        if (done) begin
            if (!m_dv || rd) begin
                m_d  = word;
                m_dv = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (rd && m_dv) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("D",    32'(D),    32'(m_d));
        check_eq("DV",   32'(DV),   32'(m_dv));
        check_eq("BUSY", 32'(BUSY), 32'(m_active));
        check_eq("ERR",  32'(ERR),  32'(m_err));
        check_eq("OVR",  32'(OVR),  32'(m_ovr));
        check_eq("PERR", 32'(PERR), 32'(m_perr));
    endtask

    // One clock: drive inputs, clock edge, update model, compare after the edge
    task automatic step(input bit sen, input bit sync, input bit sin, input bit rd);
        SEN  = sen;
        SYNC = sync;
        SIN  = sin;
        RD   = rd;
        @(posedge CLK);
        model_edge(sen, sync, sin, rd);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #2;
        Clr = 1'b0;
        model_reset();
        #1;
        compare_all();
        #4;
        Clr = 1'b1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit pflip, input bit rd_last);
        for (int i = WIDTH - 1; i >= 0; i--)
            step(1'b1, i == WIDTH - 1, w[i], rd_last && !PAR_EN && (i == 0));
        if (PAR_EN) step(1'b1, 1'b0, (^w) ^ pflip, rd_last);
    endtask

    initial begin
        Clr  = 1'b0;
        SIN  = 1'b0;
        SEN  = 1'b0;
        SYNC = 1'b0;
        RD   = 1'b0;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        compare_all();
        #3;
        Clr = 1'b1;

        // Single word A5
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 1'b0, 1'b0);
        check_eq("a5_D",    32'(D),    32'hA5);
        check_eq("a5_DV",   32'(DV),   32'd1);
        check_eq("a5_BUSY", 32'(BUSY), 32'd0);
        check_eq("a5_ERR",  32'(ERR),  32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("a5_rd_DV", 32'(DV), 32'd0);

        // Back-to-back words with reads
        send_word(8'h3C, 1'b0, 1'b0);
        check_eq("b2b_D0", 32'(D), 32'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hC3, 1'b0, 1'b0);
        check_eq("b2b_D1",  32'(D),   32'hC3);
        check_eq("b2b_OVR", 32'(OVR), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: second word completes while first unread
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        check_eq("ovr_D",   32'(D),   32'h3C);
        check_eq("ovr_OVR", 32'(OVR), 32'd1);
        check_eq("ovr_DV",  32'(DV),  32'd1);

        // Read on the completion cycle avoids the overrun
        do_reset();
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b1);
        check_eq("rdc_D",   32'(D),   32'hFF);
        check_eq("rdc_DV",  32'(DV),  32'd1);
        check_eq("rdc_OVR", 32'(OVR), 32'd0);

        // Resync after 4 bits
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h81, 1'b0, 1'b0);
        check_eq("rs_ERR", 32'(ERR), 32'd1);
        check_eq("rs_D",   32'(D),   32'h81);

        // Reset mid-word, then bits without SYNC
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b0);
        do_reset();
        check_eq("clr_D",    32'(D),    32'h0);
        check_eq("clr_BUSY", 32'(BUSY), 32'd0);
        check_eq("clr_ERR",  32'(ERR),  32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("clr_DV",   32'(DV),   32'd0);
        check_eq("clr_BUSY2", 32'(BUSY), 32'd0);

`ifdef SER_WORD_RX_PARITY_EN
        // Parity good then bad
        do_reset();
        send_word(8'hA5, 1'b0, 1'b0);
        check_eq("par_ok_PERR", 32'(PERR), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hA5, 1'b1, 1'b0);
        check_eq("par_bad_PERR", 32'(PERR), 32'd1);
        check_eq("par_bad_D",    32'(D),    32'hA5);
        check_eq("par_bad_DV",   32'(DV),   32'd1);
`endif

        // Random traffic with SEN gaps, resyncs, reads and occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 1'($urandom), $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
